pwl_act_pipe: RTL and testbench

PWL_ACT_PIPE -- requirements
Module: pwl_act_pipe

---
 rtl/pwl_act_pipe.sv | 107 ++++++++++
 tb/tb_pwl_act_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwl_act_pipe.sv
// Piecewise-linear activation: 3-stage pipeline (input reg, LUT read, interpolation)
// with a banked, runtime-programmable segment table and one global stall signal.
module pwl_act_pipe #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int NUM_BANKS = 2,
    localparam int REM_W    = DATA_W - ADDR_W,
    localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] z_value,
    input  logic [BANK_W-1:0] in_bank,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    input  logic              cfg_we,
    input  logic [BANK_W-1:0] cfg_bank,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data
);

    localparam int PROD_W = DATA_W + 1 + REM_W;
    localparam logic [ADDR_W-1:0] TOP_SEG = {1'b0, {(ADDR_W-1){1'b1}}};

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // The whole pipe moves as one; it only freezes when the output is held.
    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    logic [DATA_W-1:0] lut [NUM_BANKS][2**ADDR_W];

    logic              s1_valid;
    logic [DATA_W-1:0] s1_z;
    logic [BANK_W-1:0] s1_bank;

    logic              s2_valid;
    logic [DATA_W-1:0] s2_base;
    logic [DATA_W-1:0] s2_next;
    logic [REM_W-1:0]  s2_rem;

    // LUT lookup from the S1 register
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rd_addr_n;
    logic [REM_W-1:0]  rd_rem;
    logic [DATA_W-1:0] rd_base;
    logic [DATA_W-1:0] rd_next;

    assign rd_addr   = s1_z[DATA_W-1:REM_W];
    assign rd_rem    = s1_z[REM_W-1:0];
    assign rd_addr_n = rd_addr + ADDR_W'(1);
    assign rd_base   = lut[s1_bank][rd_addr];
    // The most positive segment stays flat instead of wrapping to the most negative entry.
    assign rd_next   = (rd_addr == TOP_SEG) ? rd_base : lut[s1_bank][rd_addr_n];

    // Interpolation from the S2 register: base + floor((next - base) * rem / 2^REM_W)
    logic signed [DATA_W:0]   diff;
    logic signed [PROD_W-1:0] diff_x;
    logic signed [PROD_W-1:0] rem_x;
    logic signed [PROD_W-1:0] prod;
    logic signed [DATA_W:0]   step;
    logic signed [DATA_W:0]   interp;
    logic                     unused_bits;

    assign diff   = {s2_next[DATA_W-1], s2_next} - {s2_base[DATA_W-1], s2_base};
    assign diff_x = {{REM_W{diff[DATA_W]}}, diff};
    assign rem_x  = {{(DATA_W+1){1'b0}}, s2_rem};
    assign prod   = diff_x * rem_x;
    assign step   = prod[PROD_W-1:REM_W];
    assign interp = {s2_base[DATA_W-1], s2_base} + step;
    assign unused_bits = &{1'b0, prod[REM_W-1:0], interp[DATA_W]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_z      <= '0;
            s1_bank   <= '0;
            s2_valid  <= 1'b0;
            s2_base   <= '0;
            s2_next   <= '0;
            s2_rem    <= '0;
            out_valid <= 1'b0;
            out_a     <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            s1_z      <= z_value;
            s1_bank   <= in_bank;
            s2_valid  <= s1_valid;
            s2_base   <= rd_base;
            s2_next   <= rd_next;
            s2_rem    <= rd_rem;
            out_valid <= s2_valid;
            out_a     <= interp[DATA_W-1:0];
        end
    end

    // Table is not reset; a write in the same cycle as an S2 read is seen one cycle later.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            lut[cfg_bank][cfg_addr] <= cfg_data;
        end
    end

endmodule

// File: tb/tb_pwl_act_pipe.sv
// Bench for pwl_act_pipe: directed vector table plus hand-written stall,
// write-collision and mid-stream reset sequences.
module tb_pwl_act_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] z_value;
    logic [0:0] in_bank;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_a;
    logic       cfg_we;
    logic [0:0] cfg_bank;
    logic [3:0] cfg_addr;
    logic [7:0] cfg_data;

    pwl_act_pipe #(.DATA_W(8), .ADDR_W(4), .NUM_BANKS(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .z_value(z_value), .in_bank(in_bank),
        .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a),
        .cfg_we(cfg_we), .cfg_bank(cfg_bank), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:0] bank;
        logic [7:0] z;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs[14];
    int         n_cmp = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_e;
    int         bank1_tab[16] = '{0, 0, 0, 20, 10, -30, 0, 100, 0, 0, 0, 0, 0, 0, 0, 0};

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read on the falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic b, input logic [3:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_bank = b; cfg_addr = a; cfg_data = d;
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic b, input logic [7:0] z);
        bit acc;
        in_valid = 1'b1; in_bank = b; z_value = z;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            acc = in_ready;
            cyc();
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        chk("send_timeout", 0, 1);
    endtask

    task automatic send_lat(input logic b, input logic [7:0] z, input logic [7:0] e);
        int lat;
        exp_q.push_back(e);
        send(b, z);
        lat = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        chk("latency", lat, 3);
        cyc();
    endtask

    task automatic drain(input int budget);
        for (int t = 0; t < budget; t++) begin
            if (exp_q.size() == 0) return;
            cyc();
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    // Scoreboard: every output transfer is matched in order against exp_q.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", int'($signed(out_a)), 9999);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_a", int'($signed(out_a)), int'($signed(mon_e)));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] held;
        int         seen;

        vecs[0]  = '{1'b0, 8'h25, 8'h12};
        vecs[1]  = '{1'b0, 8'h7F, 8'h38};
        vecs[2]  = '{1'b0, 8'hF8, 8'hFC};
        vecs[3]  = '{1'b1, 8'h33, 8'h12};
        vecs[4]  = '{1'b0, 8'h00, 8'h00};
        vecs[5]  = '{1'b0, 8'h80, 8'hC0};
        vecs[6]  = '{1'b0, 8'h8F, 8'hC7};
        vecs[7]  = '{1'b0, 8'h70, 8'h38};
        vecs[8]  = '{1'b0, 8'h6F, 8'h37};
        vecs[9]  = '{1'b1, 8'h3F, 8'h0A};
        vecs[10] = '{1'b1, 8'h48, 8'hF6};
        vecs[11] = '{1'b1, 8'h7A, 8'h64};
        vecs[12] = '{1'b1, 8'h6F, 8'h5D};
        vecs[13] = '{1'b0, 8'hFF, 8'hFF};

        rst = 1'b0; in_valid = 1'b0; z_value = '0; in_bank = '0; out_ready = 1'b1;
        cfg_we = 1'b0; cfg_bank = '0; cfg_addr = '0; cfg_data = '0;
        cyc();
        cyc();
        @(negedge clk);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_a", int'(out_a), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        cyc();
        rst = 1'b1;

        for (int k = 0; k < 16; k++) begin
            cfg_write(1'b0, 4'(k), 8'((k < 8) ? 8 * k : 8 * (k - 16)));
        end
        for (int k = 0; k < 16; k++) begin
            cfg_write(1'b1, 4'(k), 8'(bank1_tab[k]));
        end

        // Isolated samples with exact latency
        for (int i = 0; i < 4; i++) begin
            send_lat(vecs[i].bank, vecs[i].z, vecs[i].exp);
        end
        drain(20);

        // Whole table back to back
        for (int i = 0; i < 14; i++) begin
            exp_q.push_back(vecs[i].exp);
            send(vecs[i].bank, vecs[i].z);
        end
        drain(100);

        // Output stall while streaming five samples
        seen = 0;
        held = '0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    exp_q.push_back(vecs[i].exp);
                    send(vecs[i].bank, vecs[i].z);
                end
            end
            begin
                cyc();
                cyc();
                out_ready = 1'b0;
                for (int t = 0; t < 8; t++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        chk("stall_in_ready", int'(in_ready), 0);
                        if (seen == 0) begin
                            held = out_a;
                            chk("stall_first_out", int'($signed(out_a)), int'($signed(vecs[0].exp)));
                        end else begin
                            chk("stall_hold", int'(out_a), int'(held));
                        end
                        seen++;
                    end
                    cyc();
                end
                out_ready = 1'b1;
            end
        join
        chk("stall_seen", int'(seen > 0), 1);
        drain(100);

        // LUT write colliding with the S2 read of the same entry
        exp_q.push_back(8'h10);
        in_valid = 1'b1; in_bank = 1'b0; z_value = 8'h20;
        cyc();
        in_valid = 1'b0;
        cfg_we = 1'b1; cfg_bank = 1'b0; cfg_addr = 4'd2; cfg_data = 8'd40;
        cyc();
        cfg_we = 1'b0;
        drain(20);
        exp_q.push_back(8'h28);
        send(1'b0, 8'h20);
        drain(20);
        cfg_write(1'b0, 4'd2, 8'd16);

        // Reset with samples in flight
        in_valid = 1'b1; in_bank = 1'b0; z_value = 8'h25;
        cyc();
        z_value = 8'h7F;
        cyc();
        z_value = 8'hF8;
        rst = 1'b0;
        cyc();
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_out_valid", int'(out_valid), 0);
        chk("midreset_out_a", int'(out_a), 0);
        chk("midreset_in_ready", int'(in_ready), 1);
        for (int t = 0; t < 6; t++) begin
            cyc();
            @(negedge clk);
            chk("no_stale_output", int'(out_valid), 0);
        end
        cyc();
        send_lat(1'b0, 8'h25, 8'h12);
        send_lat(1'b1, 8'h33, 8'h12);
        drain(20);
        chk("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
